pe_psum_accumulator: RTL and testbench
======================================

Name: pe_psum_accumulator

Overview:
- Downstream stage of the fusion-unit PE; consumes the PE's 20-bit signed PE_sum stream.
- Accumulates a configured number of PE_sum samples per output window into a wide saturating accumulator.
- Requantizes each finished window to OUT_W bits with round-half-up, optional ReLU and saturation.
- Emits each window result through a valid/ready output register; runs a configured number of windows per job, then pulses done.

Parameters:
- IN_W, 20, width of signed PE_sum input
- ACC_W, 32, accumulator width, signed
- OUT_W, 8, requantized output width, signed
- CNT_W, 16, width of window-length and window-count fields

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle job start pulse
- cfg_len  in  CNT_W  samples per window; 0 treated as 1
- cfg_windows  in  CNT_W  windows per job
- cfg_shift  in  5  requant right-shift amount, 0..ACC_W-1
- cfg_relu  in  1  clamp negative results to 0
- in_valid  in  1  PE_sum sample valid
- in_ready  out  1  sample accepted when in_valid&&in_ready
- in_sum  in  IN_W  signed PE_sum sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_W  raw saturated window sum
- out_q  out  OUT_W  requantized result
- out_ovf  out  1  accumulator saturated at least once in this window
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when last window result is accepted

Behaviour:
- Reset (async, active-high): state IDLE; accumulator, counters, out_acc, out_q = 0; out_valid, out_ovf, in_ready, busy, done = 0.
- States:
  - IDLE: cfg_start latches cfg_len, cfg_windows, cfg_shift and cfg_relu, and clears the accumulator. Next state is ACCUM, or DRAIN if cfg_windows=0.
  - ACCUM: in_ready=1 except when the pending beat is the last of a window while out_valid=1 and out_ready=0 (output register still occupied).
  - DRAIN: waits for the final out_valid to be accepted. done pulses in that accept cycle, then the block goes to IDLE. With cfg_windows=0, done pulses the cycle after cfg_start and nothing is output.
- cfg_start while busy: ignored; config registers are held for the whole job.
- Accumulate: acc_next = sat_ACC_W(acc + sign_extend(in_sum)). Saturate to +2^(ACC_W-1)-1 / -2^(ACC_W-1) and set a per-window sticky ovf.
- Window end (last beat accepted):
  - Next cycle: out_valid=1; out_acc = final saturated sum including that beat; out_q = requant(out_acc); out_ovf = sticky.
  - Same edge: accumulator, sample counter and sticky cleared, so the next window's first beat can be accepted in the following cycle with no bubble.
  - Window counter increments; after the last window the state goes to DRAIN.
- Requant:
  - shift=0: v=acc. Otherwise v = (acc + 2^(shift-1)) >>> shift, with the add done at ACC_W+1 bits.
  - If relu and v<0, v=0.
  - out_q = saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output register: holds all values while out_valid && !out_ready. Simultaneous accept of the old result and load of a new one in the same cycle is allowed.
- Latency: last input beat to out_valid is 1 cycle.
- busy=1 from the cycle after an accepted cfg_start until the cycle after done.
- Reset mid-job: everything aborts immediately to reset values; no done pulse.

Decomposition:
- Package pe_acc_pkg: state enum (IDLE, ACCUM, DRAIN), default widths, saturation limit constants.
- Sub-module psum_requant (combinational): acc, shift, relu -> out_q. Instantiated once, feeding the output register.

Test Plan:
- cfg_len=4, cfg_windows=1, shift=0, relu=0; in_sum 10,-3,7,1 -> one cycle after 4th beat: out_acc=15, out_q=15, out_ovf=0; done on accept; busy drops next cycle.
- cfg_len=2, cfg_windows=3, shift=2; pairs (5,2),(-6,0),(1,0); out_ready=1 -> out_q = 2, -1, 0 (round half up of 7/4, -6/4, 1/4); back-to-back input with no stalls, in_ready=1 throughout.
- Same job with out_ready=0 for 5 cycles after first result -> in_ready drops on the last beat of window 2; first result held stable; no data lost; results in order.
- relu=1, shift=0, cfg_len=1; in_sum -100 then 300 -> out_q=0 then 127; out_acc=-100 then 300.
- ACC_W=24; cfg_len=40; in_sum=+524287 each beat -> out_acc=8388607, out_ovf=1; next window with small inputs -> out_ovf=0.
- Assert reset mid-window (after 2 of 4 beats) -> all outputs 0 immediately; new cfg_start runs a clean job with correct sums; cfg_windows=0 -> done pulse, no out_valid.

Source files
------------

// File: rtl/pe_acc_pkg.sv
// Shared types and default widths for the PE partial-sum accumulator.
package pe_acc_pkg;

  localparam int PE_IN_W  = 20;
  localparam int PE_ACC_W = 32;
  localparam int PE_OUT_W = 8;
  localparam int PE_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } pe_acc_state_e;

endpackage

// File: rtl/psum_requant.sv
// Requantizer: round-half-up arithmetic right shift, optional ReLU,
// then saturation of the signed window sum to OUT_W bits.
module psum_requant
  import pe_acc_pkg::*;
#(
  parameter int ACC_W = PE_ACC_W,
  parameter int OUT_W = PE_OUT_W
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [4:0]       shift_i,
  input  logic             relu_i,
  output logic [OUT_W-1:0] q_o
);

  localparam logic signed [ACC_W:0] Q_MAX =
    $signed({{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] Q_MIN =
    $signed({{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] v;

  // One guard bit so the rounding add cannot wrap near the positive limit.
  always_comb begin
    ext = $signed({acc_i[ACC_W-1], acc_i});
    rnd = '0;
    if (shift_i != 5'd0) begin
      rnd = {{ACC_W{1'b0}}, 1'b1} << (shift_i - 5'd1);
    end
    v = (ext + rnd) >>> shift_i;
    if (relu_i && v[ACC_W]) begin
      v = '0;
    end
    if (v > Q_MAX) begin
      q_o = Q_MAX[OUT_W-1:0];
    end else if (v < Q_MIN) begin
      q_o = Q_MIN[OUT_W-1:0];
    end else begin
      q_o = v[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/pe_psum_accumulator.sv
// Windowed saturating accumulator for the PE_sum stream with a requantized
// valid/ready output register and per-job window sequencing.
module pe_psum_accumulator
  import pe_acc_pkg::*;
#(
  parameter int IN_W  = PE_IN_W,
  parameter int ACC_W = PE_ACC_W,
  parameter int OUT_W = PE_OUT_W,
  parameter int CNT_W = PE_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_windows,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [OUT_W-1:0] out_q,
  output logic             out_ovf,
  output logic             busy,
  output logic             done,
  output pe_acc_state_e    dbg_state
);

  pe_acc_state_e    state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d, win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, wcnt_q, wcnt_d;
  logic [4:0]       shift_q, shift_d;
  logic             relu_q, relu_d, sticky_q, sticky_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic [ACC_W-1:0] out_acc_q, out_acc_d;
  logic [OUT_W-1:0] out_qv_q, out_qv_d;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sat_sum;
  logic             sat_hit, last_beat, fire;
  logic [OUT_W-1:0] req_q;

  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-IN_W){in_sum[IN_W-1]}}, in_sum};
    sat_hit  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!sat_hit)             sat_sum = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W]) sat_sum = {1'b1, {(ACC_W-1){1'b0}}};
    else                      sat_sum = {1'b0, {(ACC_W-1){1'b1}}};
  end

  psum_requant #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_requant (
    .acc_i   (sat_sum),
    .shift_i (shift_q),
    .relu_i  (relu_q),
    .q_o     (req_q)
  );

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and a stalled output holds every field.
  // in_ready is withheld only for a window-closing beat that would need
  // the output register while it is still occupied.
  assign last_beat = (cnt_q == len_q - CNT_W'(1));
  assign in_ready  = (state_q == ST_ACCUM) && !(last_beat && out_valid_q && !out_ready);
  assign fire      = in_valid && in_ready;
  assign done      = (state_q == ST_DRAIN) && (!out_valid_q || out_ready);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_q     = out_qv_q;
  assign out_ovf   = out_ovf_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    win_d       = win_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_qv_d    = out_qv_q;
    out_ovf_d   = out_ovf_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          len_d    = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
          win_d    = cfg_windows;
          shift_d  = cfg_shift;
          relu_d   = cfg_relu;
          acc_d    = '0;
          cnt_d    = '0;
          wcnt_d   = '0;
          sticky_d = 1'b0;
          state_d  = (cfg_windows == '0) ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (fire) begin
          if (last_beat) begin
            // Result loads while the accumulator restarts for the next window.
            out_valid_d = 1'b1;
            out_acc_d   = sat_sum;
            out_qv_d    = req_q;
            out_ovf_d   = sticky_q | sat_hit;
            acc_d       = '0;
            cnt_d       = '0;
            sticky_d    = 1'b0;
            wcnt_d      = wcnt_q + CNT_W'(1);
            if (wcnt_q == win_q - CNT_W'(1)) state_d = ST_DRAIN;
          end else begin
            acc_d    = sat_sum;
            cnt_d    = cnt_q + CNT_W'(1);
            sticky_d = sticky_q | sat_hit;
          end
        end
      end
      ST_DRAIN: begin
        if (done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      win_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_qv_q    <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      win_q       <= win_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_qv_q    <= out_qv_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Bench for pe_psum_accumulator: directed and random jobs compared against
// an arithmetic window-sum / requant model.
module tb_pe_psum_accumulator;
  import pe_acc_pkg::*;

  localparam int IN_W  = 20;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  localparam int CNT_W = 16;
  localparam int RW    = 1 + OUT_W + ACC_W;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W - 1));

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_start = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic [CNT_W-1:0] cfg_windows = '0;
  logic [4:0]       cfg_shift = '0;
  logic             cfg_relu = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_sum = '0;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [OUT_W-1:0] out_q;
  logic             out_ovf;
  logic             busy;
  logic             done;
  pe_acc_state_e    dbg_state;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int stalls;
  int in_q[$];
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];

  pe_psum_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_windows(cfg_windows), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_q(out_q), .out_ovf(out_ovf), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // consumer: 0 = always ready, 1 = random, 2 = blocked
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) got_q.push_back({out_ovf, out_q, out_acc});
    if (done) done_cnt++;
  end

  // ---------------- reference model ----------------
  function automatic longint requant_ref(longint acc, int sh, bit relu);
    longint v;
    if (sh == 0) v = acc;
    else         v = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  task automatic build_expected(input int len, input int win, input int sh, input bit relu);
    int n, k;
    longint acc, v;
    bit ovf;
    logic [OUT_W-1:0] qv;
    logic [ACC_W-1:0] av;
    n = (len == 0) ? 1 : len;
    k = 0;
    exp_q.delete();
    for (int w = 0; w < win; w++) begin
      acc = 0;
      ovf = 1'b0;
      for (int j = 0; j < n; j++) begin
        acc = acc + in_q[k];
        k++;
        if (acc > ACC_MAX) begin acc = ACC_MAX; ovf = 1'b1; end
        if (acc < ACC_MIN) begin acc = ACC_MIN; ovf = 1'b1; end
      end
      v  = requant_ref(acc, sh, relu);
      qv = v[OUT_W-1:0];
      av = acc[ACC_W-1:0];
      exp_q.push_back({ovf, qv, av});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic start_job(input int len, input int win, input int sh, input bit relu);
    cfg_len     = len[CNT_W-1:0];
    cfg_windows = win[CNT_W-1:0];
    cfg_shift   = sh[4:0];
    cfg_relu    = relu;
    cfg_start   = 1'b1;
    @(posedge clk); #1;
    cfg_start   = 1'b0;
  endtask

  task automatic drive_inputs(input bit gaps, output int n_stall);
    int s;
    bit fired;
    n_stall = 0;
    while (in_q.size() > 0) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      s        = in_q[0];
      in_valid = 1'b1;
      in_sum   = s[IN_W-1:0];
      @(negedge clk);
      fired = in_ready;
      @(posedge clk); #1;
      if (fired) void'(in_q.pop_front());
      else n_stall++;
      if (n_stall > 5000) begin
        checks++; errors++;
        $display("FAIL input_timeout got %0d stalls required <= 5000", n_stall);
        in_q.delete();
      end
    end
    in_valid = 1'b0;
    in_sum   = '0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 30000 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL done_timeout got 0 required 1"); end
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int len, input int win, input int sh, input bit relu, input bit gaps);
    got_q.delete();
    build_expected(len, win, sh, relu);
    start_job(len, win, sh, relu);
    drive_inputs(gaps, stalls);
    wait_done();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 8;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid); end
    if (in_ready  !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b required 0", in_ready); end
    if (busy      !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
    if (done      !== 1'b0) begin errors++; $display("FAIL rst_done got %b required 0", done); end
    if (out_acc   !== '0)   begin errors++; $display("FAIL rst_out_acc got %h required 0", out_acc); end
    if (out_q     !== '0)   begin errors++; $display("FAIL rst_out_q got %h required 0", out_q); end
    if (out_ovf   !== 1'b0) begin errors++; $display("FAIL rst_out_ovf got %b required 0", out_ovf); end
    if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d required 0", dbg_state); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int vals[4] = '{10, -3, 7, 1};
    int s;
    ready_mode = 0;
    start_job(4, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      s = vals[i];
      in_valid = 1'b1;
      in_sum   = s[IN_W-1:0];
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready[%0d] got %b required 1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks += 6;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b required 1", out_valid); end
    if (out_acc !== 32'd15) begin errors++; $display("FAIL basic_acc got %0d required 15", $signed(out_acc)); end
    if (out_q !== 8'd15)    begin errors++; $display("FAIL basic_q got %0d required 15", $signed(out_q)); end
    if (out_ovf !== 1'b0)   begin errors++; $display("FAIL basic_ovf got %b required 0", out_ovf); end
    if (done !== 1'b1)      begin errors++; $display("FAIL basic_done got %b required 1", done); end
    if (busy !== 1'b1)      begin errors++; $display("FAIL basic_busy got %b required 1", busy); end
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy_drop got %b required 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL basic_done_pulse got %b required 0", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_clear got %b required 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [OUT_W-1:0] want_q[3] = '{8'd2, 8'hFF, 8'd0};
    ready_mode = 0;
    in_q = '{5, 2, -6, 0, 1, 0};
    run_job(2, 3, 2, 0, 0);
    checks += 2;
    if (stalls !== 0) begin errors++; $display("FAIL b2b_stalls got %0d required 0", stalls); end
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks += 2;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_result[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
      if (got_q[i][ACC_W+OUT_W-1:ACC_W] !== want_q[i]) begin
        errors++; $display("FAIL b2b_q[%0d] got %h required %h", i, got_q[i][ACC_W+OUT_W-1:ACC_W], want_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] held;
    bit seen;
    int d0;
    d0 = done_cnt;
    ready_mode = 2;
    in_q = '{5, 2, -6, 0, 1, 0};
    got_q.delete();
    build_expected(2, 3, 2, 0);
    start_job(2, 3, 2, 0);
    fork
      drive_inputs(1'b0, stalls);
      begin
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = out_valid;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_first_valid got 0 required 1"); end
        held = {out_ovf, out_q, out_acc};
        for (int c = 0; c < 5; c++) begin
          if (c == 1) begin
            cfg_len = 16'd1; cfg_windows = 16'd0; cfg_start = 1'b1;
          end
          @(negedge clk);
          cfg_start = 1'b0;
          checks++;
          if (!out_valid || {out_ovf, out_q, out_acc} !== held) begin
            errors++; $display("FAIL bp_hold[%0d] got %b/%h required 1/%h", c, out_valid, {out_ovf, out_q, out_acc}, held);
          end
        end
        ready_mode = 0;
      end
    join
    wait_done();
    checks += 3;
    if (stalls == 0) begin errors++; $display("FAIL bp_in_ready_drop got %0d stalls required > 0", stalls); end
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done_count got %0d required 1", done_cnt - d0); end
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_result[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_relu();
    ready_mode = 1;
    in_q = '{-100, 300};
    run_job(1, 2, 0, 1, 1);
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL relu_count got %0d required 2", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL relu_result[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 2) begin
      checks += 4;
      if (got_q[0][ACC_W+OUT_W-1:ACC_W] !== 8'd0)   begin errors++; $display("FAIL relu_q0 got %h required 00", got_q[0][ACC_W+OUT_W-1:ACC_W]); end
      if (got_q[1][ACC_W+OUT_W-1:ACC_W] !== 8'd127) begin errors++; $display("FAIL relu_q1 got %h required 7f", got_q[1][ACC_W+OUT_W-1:ACC_W]); end
      if (got_q[0][ACC_W-1:0] !== 32'hFFFF_FF9C)    begin errors++; $display("FAIL relu_acc0 got %h required ffffff9c", got_q[0][ACC_W-1:0]); end
      if (got_q[1][ACC_W-1:0] !== 32'd300)          begin errors++; $display("FAIL relu_acc1 got %h required 12c", got_q[1][ACC_W-1:0]); end
    end
  endtask

  task automatic test_saturation();
    ready_mode = 0;
    in_q.delete();
    for (int i = 0; i < 4200; i++) in_q.push_back(524287);
    for (int i = 0; i < 4200; i++) in_q.push_back(int'($urandom_range(0, 2000)) - 1000);
    for (int i = 0; i < 4200; i++) in_q.push_back(-524288);
    run_job(4200, 3, 31, 0, 0);
    checks++;
    if (got_q.size() != 3) begin errors++; $display("FAIL sat_count got %0d required 3", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_result[%0d] got %h required %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 3) begin
      checks += 4;
      if (got_q[0][ACC_W-1:0] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos_acc got %h required 7fffffff", got_q[0][ACC_W-1:0]); end
      if (got_q[0][RW-1] !== 1'b1)               begin errors++; $display("FAIL sat_pos_ovf got %b required 1", got_q[0][RW-1]); end
      if (got_q[1][RW-1] !== 1'b0)               begin errors++; $display("FAIL sat_small_ovf got %b required 0", got_q[1][RW-1]); end
      if (got_q[2][ACC_W-1:0] !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg_acc got %h required 80000000", got_q[2][ACC_W-1:0]); end
    end
  endtask

  task automatic test_random();
    int len, win, sh, d0;
    bit relu;
    ready_mode = 1;
    for (int job = 0; job < 8; job++) begin
      len  = $urandom_range(0, 6);
      win  = $urandom_range(1, 4);
      sh   = $urandom_range(0, 12);
      relu = $urandom_range(0, 1);
      in_q.delete();
      for (int i = 0; i < ((len == 0) ? 1 : len) * win; i++)
        in_q.push_back(int'($urandom_range(0, 1048575)) - 524288);
      d0 = done_cnt;
      run_job(len, win, sh, relu, 1);
      checks += 2;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL rnd%0d_done got %0d required 1", job, done_cnt - d0); end
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d required %0d", job, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_result[%0d] got %h required %h", job, i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int vals[3] = '{3, 4, 5};
    int s, d0;
    ready_mode = 2;
    start_job(2, 2, 0, 0);
    for (int i = 0; i < 3; i++) begin
      s = vals[i];
      in_valid = 1'b1;
      in_sum   = s[IN_W-1:0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b required 0", out_valid); end
    if (out_acc !== '0)     begin errors++; $display("FAIL mid_out_acc got %h required 0", out_acc); end
    if (out_q !== '0)       begin errors++; $display("FAIL mid_out_q got %h required 0", out_q); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_in_ready got %b required 0", in_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy got %b required 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL mid_done got %b required 0", done); end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done got %0d required %0d", done_cnt, d0); end
    @(posedge clk); #1;
    ready_mode = 0;
    in_q = '{1, 2, 3, 4};
    run_job(4, 1, 0, 0, 0);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL clean_count got %0d required 1", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clean_result got %h required %h", got_q[i], exp_q[i]); end
    end
    got_q.delete();
    start_job(3, 0, 0, 0);
    @(negedge clk);
    checks += 2;
    if (done !== 1'b1)      begin errors++; $display("FAIL zero_win_done got %b required 1", done); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_win_valid got %b required 0", out_valid); end
    @(negedge clk);
    checks += 3;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_win_pulse got %b required 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_win_busy got %b required 0", busy); end
    if (got_q.size() != 0) begin errors++; $display("FAIL zero_win_output got %0d required 0", got_q.size()); end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_relu();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
